// File: rtl/input_vc_controller_base.sv
// Input VC controller: per-VC flit FIFO, IDLE/VA/ACTIVE state machine and upstream credit return.
// Optional protocol error detection is compiled in with INVC_ERR_CHECK_EN.
`ifndef DW
`define DW 8
`endif
`ifndef BUF_DEPTH_LOG
`define BUF_DEPTH_LOG 2
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module input_vc_controller_base #(
  parameter logic [1:0] VCID = 2'd0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           valid,
  input  logic [`DW-1:0] data,
  output logic           credit_upd,
  output logic           va_req,
  input  logic           va_grant,
  output logic [`DW-1:0] flit_out,
  output logic           flit_out_valid,
  input  logic           sa_grant,
  output logic           err
);
  localparam int unsigned DW    = `DW;
  localparam int unsigned AW    = `BUF_DEPTH_LOG;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [PW-1:0] PEND_INIT = PW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VA     = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] pend_cnt, pend_nxt;
  logic [1:0]    state, state_nxt;
  logic [1:0]    front_type;
  logic          empty, full, vc_match, push, pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign flit_out   = mem[rd_ptr[AW-1:0]];
  assign front_type = flit_out[DW-3:DW-4];

  assign va_req         = (state == S_VA);
  assign flit_out_valid = (state == S_ACTIVE) && !empty;
  assign pop            = sa_grant && flit_out_valid;
  assign vc_match       = valid && (data[DW-1:DW-2] == VCID);
  // A full FIFO still takes a flit when the front slot frees in the same cycle.
  assign push           = vc_match && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Credits owed upstream: one emitted per cycle, one added per freed slot.
  always_comb begin
    pend_nxt = pend_cnt;
    if (pend_cnt != '0) pend_nxt = pend_nxt - PW'(1);
    if (pop)            pend_nxt = pend_nxt + PW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_cnt   <= PEND_INIT;
      credit_upd <= 1'b0;
    end else begin
      pend_cnt   <= pend_nxt;
      credit_upd <= (pend_cnt != '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!empty && front_type == `HEAD) state_nxt = S_VA;
      S_VA:     if (va_grant) state_nxt = S_ACTIVE;
      S_ACTIVE: if (pop && front_type == `TAIL) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

`ifdef INVC_ERR_CHECK_EN
  logic err_q;
  logic err_set;

  assign err_set = (vc_match && full && !pop)
                || (state == S_IDLE && !empty && front_type != `HEAD)
                || (pend_nxt == PW'(DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_q | err_set;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
